// File: rtl/fp_issue_stage_gen.sv
// FP issue stage: per-lane hold register, issue/replay payload mux, selective-flush kill.
// The div/sqrt slot pool is built only when FP_ISSUE_LONG_OP_TRACK_EN is defined.
module fp_issue_stage_gen #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned ENTRY_W    = 64,
  parameter int unsigned AL_W       = 6,
  parameter int unsigned IQ_W       = 4,
  parameter int unsigned LONG_SLOTS = 1,
  parameter int unsigned LONG_LAT   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0]         prev_valid_i,
  input  logic [LANES*IQ_W-1:0]    prev_iqptr_i,
  input  logic                     stall_i,
  input  logic                     clear_i,
  input  logic [LANES*ENTRY_W-1:0] iss_data_i,
  input  logic [LANES*AL_W-1:0]    iss_alptr_i,
  input  logic [LANES-1:0]         iss_long_i,
  input  logic                     replay_i,
  input  logic [LANES-1:0]         rp_valid_i,
  input  logic [LANES*ENTRY_W-1:0] rp_data_i,
  input  logic [LANES*AL_W-1:0]    rp_alptr_i,
  input  logic [LANES-1:0]         rp_long_i,
  input  logic                     flush_phase_i,
  input  logic                     flush_all_i,
  input  logic [AL_W-1:0]          flush_head_i,
  input  logic [AL_W-1:0]          flush_tail_i,
  output logic [LANES-1:0]         issue_o,
  output logic [LANES*IQ_W-1:0]    issue_ptr_o,
  output logic [LANES-1:0]         reject_o,
  output logic [LANES-1:0]         rr_valid_o,
  output logic [LANES*ENTRY_W-1:0] rr_data_o,
  output logic [LANES*AL_W-1:0]    rr_alptr_o,
  output logic                     rr_replay_o,
  output logic [LONG_SLOTS-1:0]    long_busy_o
);

  // Circular range [h, t) over the active list; h == t is empty unless flushing everything.
  function automatic logic in_range(input logic [AL_W-1:0] p, input logic [AL_W-1:0] h,
                                    input logic [AL_W-1:0] t, input logic all);
    if (all)        return 1'b1;
    else if (h < t) return (p >= h) && (p < t);
    else if (h > t) return (p >= h) || (p < t);
    else            return 1'b0;
  endfunction

  logic [LANES-1:0]         held_valid;
  logic [LANES*IQ_W-1:0]    held_iq;
  logic [LANES-1:0]         sel_valid;
  logic [LANES-1:0]         sel_long;
  logic [LANES-1:0]         lane_flush;
  logic [LANES-1:0]         cand;
  logic [LANES-1:0]         reject;
  logic [LANES-1:0]         issue;
  logic [LANES*ENTRY_W-1:0] sel_data;
  logic [LANES*AL_W-1:0]    sel_alptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= '0;
      held_iq    <= '0;
    end else if (!stall_i) begin
      held_valid <= prev_valid_i;
      held_iq    <= prev_iqptr_i;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (flush_phase_i &&
            in_range(iss_alptr_i[i*AL_W +: AL_W], flush_head_i, flush_tail_i, flush_all_i))
          held_valid[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_data   = replay_i ? rp_data_i  : iss_data_i;
    sel_alptr  = replay_i ? rp_alptr_i : iss_alptr_i;
    sel_long   = replay_i ? rp_long_i  : iss_long_i;
    sel_valid  = replay_i ? rp_valid_i : ({LANES{!stall_i}} & held_valid);
    lane_flush = '0;
    cand       = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_flush[i] = flush_phase_i &&
                      in_range(sel_alptr[i*AL_W +: AL_W], flush_head_i, flush_tail_i, flush_all_i);
      cand[i]       = !clear_i && sel_valid[i] && !lane_flush[i];
    end
  end

`ifdef FP_ISSUE_LONG_OP_TRACK_EN
  localparam int unsigned CNT_W = $clog2(LONG_LAT);

  logic [LONG_SLOTS-1:0]       slot_busy;
  logic [LONG_SLOTS-1:0]       slot_take;
  logic [LONG_SLOTS*AL_W-1:0]  slot_alptr;
  logic [LONG_SLOTS*AL_W-1:0]  slot_new_alptr;
  logic [LONG_SLOTS*CNT_W-1:0] slot_cnt;
  logic                        lane_placed;

  // Lanes claim slots in ascending order; only registered-free slots are eligible,
  // so a slot released at an edge becomes usable from the following cycle.
  always_comb begin
    slot_take      = '0;
    slot_new_alptr = '0;
    reject         = '0;
    lane_placed    = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_placed = 1'b0;
      if (cand[i] && sel_long[i]) begin
        for (int unsigned s = 0; s < LONG_SLOTS; s++) begin
          if (!lane_placed && !slot_busy[s] && !slot_take[s]) begin
            slot_take[s]                      = 1'b1;
            slot_new_alptr[s*AL_W +: AL_W]    = sel_alptr[i*AL_W +: AL_W];
            lane_placed                       = 1'b1;
          end
        end
        reject[i] = !lane_placed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_busy  <= '0;
      slot_cnt   <= '0;
      slot_alptr <= '0;
    end else begin
      for (int unsigned s = 0; s < LONG_SLOTS; s++) begin
        if (slot_take[s]) begin
          slot_busy[s]                   <= 1'b1;
          slot_cnt[s*CNT_W +: CNT_W]     <= CNT_W'(LONG_LAT - 1);
          slot_alptr[s*AL_W +: AL_W]     <= slot_new_alptr[s*AL_W +: AL_W];
        end else if (slot_busy[s]) begin
          if ((flush_phase_i && in_range(slot_alptr[s*AL_W +: AL_W], flush_head_i,
                                         flush_tail_i, flush_all_i)) ||
              (slot_cnt[s*CNT_W +: CNT_W] == '0)) begin
            slot_busy[s]               <= 1'b0;
            slot_cnt[s*CNT_W +: CNT_W] <= '0;
          end else begin
            slot_cnt[s*CNT_W +: CNT_W] <= slot_cnt[s*CNT_W +: CNT_W] - CNT_W'(1);
          end
        end
      end
    end
  end

  assign long_busy_o = slot_busy;
`else
  // Without slot tracking the long flags carry no meaning and never cause a reject.
  assign reject      = sel_long & '0;
  assign long_busy_o = '0;
`endif

  assign issue       = cand & ~reject;
  assign issue_o     = issue;
  assign reject_o    = reject;
  assign issue_ptr_o = held_iq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_valid_o  <= '0;
      rr_data_o   <= '0;
      rr_alptr_o  <= '0;
      rr_replay_o <= 1'b0;
    end else begin
      rr_valid_o  <= issue;
      rr_data_o   <= sel_data;
      rr_alptr_o  <= sel_alptr;
      rr_replay_o <= replay_i;
    end
  end

endmodule

// File: tb/tb_fp_issue_stage_gen.sv
// Self-checking bench for fp_issue_stage_gen at default parameters: directed vector table,
// hand sequences for slot/stall/reset corners, and a randomized run against a reference model.
module tb_fp_issue_stage_gen;

`ifdef FP_ISSUE_LONG_OP_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif
  localparam int L = 2, EW = 64, AW = 6, QW = 4, NS = 1, LAT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [L-1:0]  prev_valid, iss_long, rp_valid, rp_long;
  logic [L*QW-1:0] prev_iq;
  logic          stall, clr, replay, fph, fall;
  logic [L*EW-1:0] iss_data, rp_data;
  logic [L*AW-1:0] iss_alptr, rp_alptr;
  logic [AW-1:0] fhead, ftail;
  logic [L-1:0]  issue, reject, rr_valid;
  logic [L*QW-1:0] issue_ptr;
  logic [L*EW-1:0] rr_data;
  logic [L*AW-1:0] rr_alptr;
  logic          rr_replay;
  logic [NS-1:0] long_busy;

  int n_cmp = 0;
  int n_fail = 0;

  fp_issue_stage_gen #(.LANES(L), .ENTRY_W(EW), .AL_W(AW), .IQ_W(QW),
                       .LONG_SLOTS(NS), .LONG_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .prev_valid_i(prev_valid), .prev_iqptr_i(prev_iq),
    .stall_i(stall), .clear_i(clr), .iss_data_i(iss_data), .iss_alptr_i(iss_alptr),
    .iss_long_i(iss_long), .replay_i(replay), .rp_valid_i(rp_valid), .rp_data_i(rp_data),
    .rp_alptr_i(rp_alptr), .rp_long_i(rp_long), .flush_phase_i(fph), .flush_all_i(fall),
    .flush_head_i(fhead), .flush_tail_i(ftail), .issue_o(issue), .issue_ptr_o(issue_ptr),
    .reject_o(reject), .rr_valid_o(rr_valid), .rr_data_o(rr_data), .rr_alptr_o(rr_alptr),
    .rr_replay_o(rr_replay), .long_busy_o(long_busy));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    prev_valid = '0; prev_iq = '0; stall = 1'b0; clr = 1'b0; iss_data = '0;
    iss_alptr = '0; iss_long = '0; replay = 1'b0; rp_valid = '0; rp_data = '0;
    rp_alptr = '0; rp_long = '0; fph = 1'b0; fall = 1'b0; fhead = '0; ftail = '0;
  endtask

  // ---------------- reference model ----------------
  bit          m_hv[L];
  logic [QW-1:0] m_hiq[L];
  bit          m_busy[NS];
  int          m_exp[NS];
  logic [AW-1:0] m_salp[NS];
  int          ecount;
  int          alloc_s[L];
  logic [L-1:0] e_iss, e_rej, e_rrv;
  logic [L*EW-1:0] e_d, e_rrd;
  logic [L*AW-1:0] e_a, e_rra;
  logic        e_rrp;

  // Membership as modular distance from head: offset < span.
  function automatic bit inr(input logic [AW-1:0] p, input logic [AW-1:0] h,
                             input logic [AW-1:0] t, input bit all);
    int span, off;
    if (all) return 1'b1;
    span = (int'(t) - int'(h) + 64) % 64;
    off  = (int'(p) - int'(h) + 64) % 64;
    return off < span;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin m_hv[i] = 1'b0; m_hiq[i] = '0; end
    for (int s = 0; s < NS; s++) begin m_busy[s] = 1'b0; m_exp[s] = 0; m_salp[s] = '0; end
    ecount = 0;
    e_rrv = '0; e_rrd = '0; e_rra = '0; e_rrp = 1'b0;
  endtask

  task automatic model_eval();
    int freeq[$];
    bit sv, lg, cnd;
    logic [AW-1:0] a;
    freeq = {};
    for (int s = 0; s < NS; s++) if (!m_busy[s]) freeq.push_back(s);
    e_d = replay ? rp_data : iss_data;
    e_a = replay ? rp_alptr : iss_alptr;
    for (int i = 0; i < L; i++) begin
      sv  = replay ? rp_valid[i] : (!stall && m_hv[i]);
      lg  = replay ? rp_long[i] : iss_long[i];
      a   = e_a[i*AW +: AW];
      cnd = !clr && sv && !(fph && inr(a, fhead, ftail, fall));
      e_rej[i] = 1'b0;
      alloc_s[i] = -1;
      if (TRACK && cnd && lg) begin
        if (freeq.size() > 0) alloc_s[i] = freeq.pop_front();
        else e_rej[i] = 1'b1;
      end
      e_iss[i] = cnd && !e_rej[i];
    end
  endtask

  task automatic model_edge();
    ecount++;
    for (int s = 0; s < NS; s++) begin
      if (m_busy[s] && fph && inr(m_salp[s], fhead, ftail, fall)) m_busy[s] = 1'b0;
      if (m_busy[s] && ecount >= m_exp[s]) m_busy[s] = 1'b0;
    end
    for (int i = 0; i < L; i++) begin
      if (alloc_s[i] >= 0) begin
        m_busy[alloc_s[i]] = 1'b1;
        m_exp[alloc_s[i]]  = ecount + LAT;
        m_salp[alloc_s[i]] = e_a[i*AW +: AW];
      end
    end
    e_rrv = e_iss; e_rrd = e_d; e_rra = e_a; e_rrp = replay;
    for (int i = 0; i < L; i++) begin
      if (!stall) begin
        m_hv[i] = prev_valid[i]; m_hiq[i] = prev_iq[i*QW +: QW];
      end else if (fph && inr(iss_alptr[i*AW +: AW], fhead, ftail, fall)) begin
        m_hv[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [L*QW-1:0] m_iq_vec();
    logic [L*QW-1:0] v;
    for (int i = 0; i < L; i++) v[i*QW +: QW] = m_hiq[i];
    return v;
  endfunction

  function automatic logic [NS-1:0] m_busy_vec();
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = m_busy[s];
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] pv; logic [7:0] piq;
    logic stall, clr, rep; logic [1:0] rpv;
    logic fph, fall; logic [5:0] hd, tl, a0, a1;
    logic [1:0] exp_iss;
  } vec_t;

  vec_t tv[13];
  localparam logic [127:0] DV = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
  localparam logic [127:0] RV = {64'h5555_6666_7777_8888, 64'h9999_0000_EEEE_FFFF};

  initial begin
    tv[0]  = '{2'b11, 8'h21, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd1,  6'd2,  2'b11};
    tv[1]  = '{2'b11, 8'h43, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'd60, 6'd2,  6'd63, 6'd5,  2'b10};
    tv[2]  = '{2'b11, 8'h65, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 6'd0,  6'd0,  6'd10, 6'd20, 2'b00};
    tv[3]  = '{2'b11, 8'h87, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'd10, 6'd10, 6'd10, 6'd10, 2'b11};
    tv[4]  = '{2'b01, 8'h9a, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd3,  6'd4,  2'b00};
    tv[5]  = '{2'b11, 8'hbc, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 6'd0,  6'd0,  6'd7,  6'd8,  2'b10};
    tv[6]  = '{2'b11, 8'hde, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 6'd0,  6'd0,  6'd7,  6'd8,  2'b00};
    tv[7]  = '{2'b11, 8'hf1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd9,  6'd11, 2'b00};
    tv[8]  = '{2'b11, 8'h32, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'd3,  6'd8,  6'd2,  6'd7,  2'b01};
    tv[9]  = '{2'b11, 8'h54, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 6'd0,  6'd0,  6'd1,  6'd2,  2'b11};
    tv[10] = '{2'b11, 8'h76, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'd3,  6'd8,  6'd8,  6'd3,  2'b01};
    tv[11] = '{2'b00, 8'h98, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 6'd0,  6'd0,  6'd4,  6'd5,  2'b11};
    tv[12] = '{2'b11, 8'hc3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'd63, 6'd0,  6'd63, 6'd0,  2'b10};

    do_reset();
    chk("reset_rr_valid", 128'(rr_valid), 128'(0));
    chk("reset_rr_data", rr_data, 128'(0));
    chk("reset_rr_alptr", 128'(rr_alptr), 128'(0));
    chk("reset_rr_replay", 128'(rr_replay), 128'(0));
    chk("reset_issue_ptr", 128'(issue_ptr), 128'(0));
    chk("reset_long_busy", 128'(long_busy), 128'(0));
    chk("reset_issue", 128'(issue), 128'(0));

    for (int v = 0; v < 13; v++) begin
      do_reset();
      prev_valid = tv[v].pv; prev_iq = tv[v].piq;
      tick();
      prev_valid = '0; prev_iq = '0;
      stall = tv[v].stall; clr = tv[v].clr; replay = tv[v].rep; rp_valid = tv[v].rpv;
      fph = tv[v].fph; fall = tv[v].fall; fhead = tv[v].hd; ftail = tv[v].tl;
      iss_alptr = {tv[v].a1, tv[v].a0}; rp_alptr = {tv[v].a1, tv[v].a0};
      iss_data = DV; rp_data = RV;
      #1;
      chk($sformatf("vec%0d_issue", v), 128'(issue), 128'(tv[v].exp_iss));
      chk($sformatf("vec%0d_issue_ptr", v), 128'(issue_ptr), 128'(tv[v].piq));
      chk($sformatf("vec%0d_reject", v), 128'(reject), 128'(0));
      tick();
      chk($sformatf("vec%0d_rr_valid", v), 128'(rr_valid), 128'(tv[v].exp_iss));
      chk($sformatf("vec%0d_rr_replay", v), 128'(rr_replay), 128'(tv[v].rep));
      chk($sformatf("vec%0d_rr_alptr", v), 128'(rr_alptr), 128'({tv[v].a1, tv[v].a0}));
      chk($sformatf("vec%0d_rr_data", v), rr_data, tv[v].rep ? RV : DV);
    end

    // two long ops competing for a single slot, then busy window length
    do_reset();
    prev_valid = 2'b11; tick();
    prev_valid = '0; iss_long = 2'b11; iss_alptr = {6'd2, 6'd1};
    #1;
    chk("long2_issue", 128'(issue), TRACK ? 128'(2'b01) : 128'(2'b11));
    chk("long2_reject", 128'(reject), TRACK ? 128'(2'b10) : 128'(2'b00));
    tick();
    iss_long = '0;
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("busy_win_%0d", k), 128'(long_busy), 128'(TRACK && k < 16));
      tick();
    end

    // wrap-around flush kills lane 0 and frees the slot holding alptr 0
    do_reset();
    prev_valid = 2'b01; tick();
    iss_long = 2'b01; iss_alptr = '0; prev_valid = 2'b11;
    #1;
    chk("wrap_alloc_issue", 128'(issue), 128'(2'b01));
    tick();
    iss_long = '0; iss_alptr = {6'd5, 6'd63}; fph = 1'b1; fhead = 6'd60; ftail = 6'd2;
    prev_valid = 2'b01;
    #1;
    chk("wrap_issue", 128'(issue), 128'(2'b10));
    chk("wrap_busy_before", 128'(long_busy), 128'(TRACK));
    tick();
    fph = 1'b0;
    chk("wrap_busy_after", 128'(long_busy), 128'(0));
    iss_long = 2'b01; iss_alptr = {6'd0, 6'd9}; prev_valid = '0;
    #1;
    chk("realloc_issue", 128'(issue), 128'(2'b01));
    chk("realloc_reject", 128'(reject), 128'(0));
    tick();
    chk("realloc_busy", 128'(long_busy), 128'(TRACK));

    // three-cycle stall with a flush hitting lane 1's held entry
    do_reset();
    prev_valid = 2'b11; prev_iq = 8'h5a; tick();
    prev_valid = '0; prev_iq = '0; stall = 1'b1; iss_alptr = {6'd20, 6'd4};
    fph = 1'b1; fhead = 6'd16; ftail = 6'd24;
    #1 chk("stall1_issue", 128'(issue), 128'(0));
    tick(); fph = 1'b0;
    #1 chk("stall2_issue", 128'(issue), 128'(0));
    chk("stall2_ptr", 128'(issue_ptr), 128'(8'h5a));
    tick();
    #1 chk("stall3_issue", 128'(issue), 128'(0));
    tick(); stall = 1'b0;
    #1 chk("unstall_issue", 128'(issue), 128'(2'b01));
    chk("unstall_ptr", 128'(issue_ptr), 128'(8'h5a));
    tick();
    chk("unstall_rr_valid", 128'(rr_valid), 128'(2'b01));

    // asynchronous reset while a slot is mid-countdown
    do_reset();
    prev_valid = 2'b01; tick();
    iss_long = 2'b01; iss_alptr = {6'd12, 6'd30}; prev_valid = 2'b10;
    tick();
    iss_long = '0;
    repeat (8) tick();
    chk("pre_rst_busy", 128'(long_busy), 128'(TRACK));
    chk("pre_rst_rr_valid", 128'(rr_valid), 128'(2'b10));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 128'(long_busy), 128'(0));
    chk("async_rst_rr_valid", 128'(rr_valid), 128'(0));
    chk("async_rst_ptr", 128'(issue_ptr), 128'(0));
    idle();
    #2 rst_n = 1'b1;
    tick();

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      prev_valid = L'($urandom); prev_iq = (L*QW)'($urandom);
      stall = ($urandom % 4) == 0; clr = ($urandom % 10) == 0; replay = ($urandom % 5) == 0;
      rp_valid = L'($urandom);
      iss_data = {$urandom, $urandom, $urandom, $urandom};
      rp_data = {$urandom, $urandom, $urandom, $urandom};
      iss_alptr = (L*AW)'($urandom); rp_alptr = (L*AW)'($urandom);
      iss_long = {($urandom % 3) == 0, ($urandom % 3) == 0};
      rp_long = {($urandom % 3) == 0, ($urandom % 3) == 0};
      fph = ($urandom % 4) == 0; fall = ($urandom % 16) == 0;
      fhead = AW'($urandom); ftail = AW'($urandom);
      #1;
      model_eval();
      chk($sformatf("rnd%0d_issue", c), 128'(issue), 128'(e_iss));
      chk($sformatf("rnd%0d_reject", c), 128'(reject), 128'(e_rej));
      chk($sformatf("rnd%0d_ptr", c), 128'(issue_ptr), 128'(m_iq_vec()));
      chk($sformatf("rnd%0d_busy", c), 128'(long_busy), 128'(m_busy_vec()));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("rnd%0d_rr_valid", c), 128'(rr_valid), 128'(e_rrv));
      chk($sformatf("rnd%0d_rr_data", c), rr_data, e_rrd);
      chk($sformatf("rnd%0d_rr_alptr", c), 128'(rr_alptr), 128'(e_rra));
      chk($sformatf("rnd%0d_rr_replay", c), 128'(rr_replay), 128'(e_rrp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
